// File: rtl/dither_pkg.sv
// Shared types for the Floyd-Steinberg frame scheduler: FSM states, the
// neighbour mask payload, default frame size and the edge-mask helper.
package dither_pkg;

    localparam int unsigned DEF_IMG_W = 320;
    localparam int unsigned DEF_IMG_H = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    // Diffusion enables; e is the pixel ahead in the current scan direction
    typedef struct packed {
        logic e;
        logic sw;
        logic s;
        logic se;
    } nb_mask_t;

    // Suppress diffusion across image edges; dir=1 mirrors the row
    function automatic nb_mask_t calc_mask(input logic at_first, input logic at_last,
                                           input logic at_bottom, input logic dir);
        nb_mask_t m;
        m.s  = ~at_bottom;
        m.e  = dir ? ~at_first : ~at_last;
        m.sw = m.s & (dir ? ~at_last : ~at_first);
        m.se = m.s & (dir ? ~at_first : ~at_last);
        return m;
    endfunction

endpackage

// File: rtl/dither_coord_counter.sv
// Raster x/y/address counters with row wrap and optional serpentine direction
// (DITHER_SERPENTINE_EN). Address is tracked incrementally, no multiplier.
module dither_coord_counter #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [XW-1:0]     x_o,
    output logic [YW-1:0]     y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              dir_o,
    output logic [XW-1:0]     x_nxt_o,
    output logic [YW-1:0]     y_nxt_o,
    output logic              dir_nxt_o,
    output logic              last_o
);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic              row_end;

    assign row_end = dir_q ? (x_q == '0) : (x_q == XW'(IMG_W - 1));
    assign last_o  = row_end & (y_q == YW'(IMG_H - 1));

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        dir_d  = dir_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            dir_d  = 1'b0;
        end else if (adv_i && !last_o) begin
            if (row_end) begin
                y_d = y_q + YW'(1);
`ifdef DITHER_SERPENTINE_EN
                // x stays put: the next row starts at the column this one ended on
                dir_d  = ~dir_q;
                addr_d = addr_q + ADDR_W'(IMG_W);
`else
                x_d    = '0;
                addr_d = addr_q + ADDR_W'(1);
`endif
            end else begin
`ifdef DITHER_SERPENTINE_EN
                if (dir_q) begin
                    x_d    = x_q - XW'(1);
                    addr_d = addr_q - ADDR_W'(1);
                end else begin
                    x_d    = x_q + XW'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
`else
                x_d    = x_q + XW'(1);
                addr_d = addr_q + ADDR_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
            dir_q  <= dir_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign addr_o    = addr_q;
    assign dir_o     = dir_q;
    assign x_nxt_o   = x_d;
    assign y_nxt_o   = y_d;
    assign dir_nxt_o = dir_d;

endmodule

// File: rtl/dither_raster_scheduler.sv
// Frame scheduler: walks an IMG_W x IMG_H frame issuing one handshaked step per
// pixel with an edge-aware diffusion mask. Serpentine scan via DITHER_SERPENTINE_EN.
module dither_raster_scheduler
    import dither_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned ADDR_W = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       step_ready_i,
    output logic                       step_valid_o,
    output logic [ADDR_W-1:0]          pix_addr_o,
    output logic [$clog2(IMG_W)-1:0]   pix_x_o,
    output logic [$clog2(IMG_H)-1:0]   pix_y_o,
    output nb_mask_t                   nb_mask_o,
    output logic                       scan_dir_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    sched_state_e state_q, state_d;
    logic         step_valid_q, step_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    nb_mask_t     mask_q, mask_d;
    logic         cnt_clear, cnt_adv, cnt_last;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          dir_nxt;

    dither_coord_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .XW     (XW),
        .YW     (YW)
    ) u_coord (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .adv_i     (cnt_adv),
        .x_o       (pix_x_o),
        .y_o       (pix_y_o),
        .addr_o    (pix_addr_o),
        .dir_o     (scan_dir_o),
        .x_nxt_o   (x_nxt),
        .y_nxt_o   (y_nxt),
        .dir_nxt_o (dir_nxt),
        .last_o    (cnt_last)
    );

    // Next state plus registered-output precompute; abort beats a handshake
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_ISSUE;
                    cnt_clear = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (step_ready_i) begin
                    cnt_adv = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        step_valid_d = (state_d == ST_ISSUE);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        mask_d       = '0;
        if (state_d == ST_ISSUE) begin
            mask_d = calc_mask(x_nxt == '0, x_nxt == XW'(IMG_W - 1),
                               y_nxt == YW'(IMG_H - 1), dir_nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            step_valid_q <= step_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mask_q       <= mask_d;
        end
    end

    assign step_valid_o = step_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign nb_mask_o    = mask_q;

endmodule

// File: doc/dither_raster_scheduler.md
# dither_raster_scheduler

Frame-level scheduler for the Floyd-Steinberg per-pixel datapath. On `start` it walks every pixel of an `IMG_W` x `IMG_H` frame in raster order and issues one step request per pixel, with the pixel address and a neighbour-enable mask that suppresses error diffusion past the image edges. It holds each request until the per-pixel loop controller accepts it, then reports frame completion. It sits between the host or trigger logic and the per-pixel dithering loop controller.

## Interface
- `IMG_W`, 320, frame width in pixels (>= 2)
- `IMG_H`, 240, frame height in pixels (>= 2)
- `ADDR_W`, 17, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin a frame; sampled only in IDLE
- `abort` in 1: cancel the frame in progress
- `step_ready` in 1: the per-pixel loop accepts the current step
- `step_valid` out 1: step request for the pixel on `pix_addr`
- `pix_addr` out ADDR_W: linear address, y*IMG_W + x
- `pix_x` out $clog2(IMG_W): current column
- `pix_y` out $clog2(IMG_H): current row
- `nb_mask` out 4: diffusion enables {E, SW, S, SE}, where E is the pixel ahead in scan order
- `scan_dir` out 1: 0 = left-to-right, 1 = right-to-left
- `busy` out 1: a frame is in progress
- `done` out 1: one-cycle pulse when the frame completes

## Operation
- States are IDLE, ISSUE and DONE.
- IDLE:
  - `start`=1 → ISSUE, with x=0, y=0, addr=0.
- ISSUE:
  - `step_valid`=1. Address, coordinates and mask are stable until the handshake completes.
  - A handshake occurs when `step_valid` and `step_ready` are both 1 in the same cycle.
  - On handshake, not at the end of a row: x advances by 1 and addr advances by 1.
  - On handshake at the end of a row: x returns to 0 and y advances by 1.
  - On handshake at the last pixel → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `abort` in ISSUE → IDLE on the next edge, with no `done` pulse. `abort` has priority over a handshake in the same cycle.
- `abort` in IDLE or DONE is ignored.
- `start` in ISSUE or DONE is ignored.
- `nb_mask` for left-to-right scan:
  - E = (x != IMG_W-1)
  - S = (y != IMG_H-1)
  - SW = S & (x != 0)
  - SE = S & (x != IMG_W-1)
- `pix_addr` is maintained incrementally with adders only. There is no multiplier.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE
  - `step_valid`, `busy`, `done`, `scan_dir` = 0
  - `pix_addr`, `pix_x`, `pix_y` = 0
  - `nb_mask` = 4'b0000
- All outputs are registered or decoded directly from registered state. There is no combinational path from `step_ready` to any output.
- Latency:
  - `start` sampled at edge N → `step_valid`=1 after edge N.
  - Back-to-back handshakes give a throughput of one pixel per cycle.
- Frame length with `step_ready` tied to 1:
  - IMG_W*IMG_H cycles in ISSUE, plus 1 DONE cycle.
  - `done` is high in cycle IMG_W*IMG_H+1 after `start`.
- The earliest next `start` is accepted in the cycle after `done`.
- Reset asserted mid-frame returns all outputs to their reset values immediately. It is asynchronous.

## Configuration
- `DITHER_SERPENTINE_EN` defined:
  - Odd rows traverse x from IMG_W-1 down to 0, with `scan_dir`=1.
  - The row-end condition on odd rows is x==0.
  - On odd rows the address decrements within the row. At the row boundary addr steps by +IMG_W: from the end of an even row to the start of the next odd row, addr goes from y*IMG_W+IMG_W-1 to (y+1)*IMG_W+IMG_W-1.
  - On odd rows the mask is mirrored: E = (x != 0), SW = S & (x != IMG_W-1), SE = S & (x != 0).
- `DITHER_SERPENTINE_EN` undefined:
  - All rows are scanned left-to-right.
  - `scan_dir` is tied to 0.

## Structure
- Shared package `dither_pkg` holds:
  - the state enum `sched_state_e`;
  - the `nb_mask_t` typedef (packed struct {e, sw, s, se});
  - the localparams for the default IMG_W and IMG_H.
- One sub-module, `dither_coord_counter`, holds the x/y/addr counters with wrap logic and the direction handling. The top-level block keeps the FSM and the mask decode.

## Test plan
Benches use IMG_W=4, IMG_H=3 unless stated.
- Tie `step_ready`=1, pulse `start` → 12 consecutive handshakes with addr 0..11, then `done` high in cycle 13 and `busy` low after it.
- Hold `step_ready`=0 for 3 cycles on pixel 5 → addr=5 and mask={1,1,1,1} stay stable, and the 4th-cycle handshake advances to addr 6.
- Check the mask at corners → (0,0)={1,0,1,1}; (3,0)={0,1,1,0}; (0,2)={1,0,0,0}; (3,2)={0,0,0,0}.
- Assert `abort` together with `step_ready` at pixel 7 → next cycle IDLE, no `done`, `busy`=0; a following `start` restarts at addr 0.
- Assert `rst` mid-frame at pixel 4; pulse `start` while busy → reset clears all outputs asynchronously; `start` while busy has no effect on sequencing.
- With `DITHER_SERPENTINE_EN` → address sequence 0,1,2,3,7,6,5,4,8,9,10,11; at (3,1) `scan_dir`=1 and mask={1,0,1,1}.
